// File: rtl/gpio_irq_pkg.sv
// Shared constants, control-state type and output-mapping helper for the
// GPIO interrupt controller.
package gpio_irq_pkg;

  localparam int NUM_PINS    = 16;
  localparam int EXT_IRQ_W   = 24;
  localparam int AGG_IRQ_BIT = 16;
  localparam int SYNC_STAGES = 2;

  // Last INIT count value before moving to LOAD (INIT spans three edges
  // counting the release edge, so both synchroniser stages hold pin data).
  localparam logic [1:0] INIT_LAST = 2'd2;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ctrl_state_e;

  // Builds the core interrupt vector from the masked pending bits: per-pin
  // lines in the low bits, their OR on the aggregate bit, the rest zero.
  function automatic logic [EXT_IRQ_W-1:0] map_ext_irq(input logic [NUM_PINS-1:0] active);
    logic [EXT_IRQ_W-1:0] v;
    v                 = {EXT_IRQ_W{1'b0}};
    v[NUM_PINS-1:0]   = active;
    v[AGG_IRQ_BIT]    = |active;
    return v;
  endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// One GPIO pin: 2-flop synchroniser, stability-counter glitch filter and the
// previous-level flop used for edge detection. A load pulse forces both the
// filtered and previous levels to the synced level so no edge results.
module gpio_pin_filter
  import gpio_irq_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic pin_in,
  output logic filt,
  output logic rise_raw,
  output logic fall_raw
);

  localparam int CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   synced_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   filt_r;
  logic                   prev_r;

  assign synced_s = sync_r[SYNC_STAGES-1];

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin_in};
    end
  end

  // Filtered level follows the synced level only after it has differed for
  // FILTER_CYCLES+1 consecutive edges; with FILTER_CYCLES=0 the count limit
  // is zero, so the first differing edge updates immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= 1'b0;
    end else if (load) begin
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= synced_s;
    end else if (synced_s == filt_r) begin
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= filt_r;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= synced_s;
    end else begin
      cnt_r  <= cnt_r + CNT_ONE;
      filt_r <= filt_r;
    end
  end

  // Previous filtered level, seeded from the synced level on load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= 1'b0;
    end else if (load) begin
      prev_r <= synced_s;
    end else begin
      prev_r <= filt_r;
    end
  end

  assign filt     = filt_r;
  assign rise_raw = filt_r & ~prev_r;
  assign fall_raw = ~filt_r & prev_r;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: per-pin filtering and edge detection, a
// write-1-to-clear pending register, and the mapping onto the core's
// ext_interrupts vector. A small start-up FSM suppresses edges until the
// synchronisers hold real pin data.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PINS-1:0]  pin_in,
  input  logic [NUM_PINS-1:0]  irq_mask,
  input  logic [NUM_PINS-1:0]  rise_en,
  input  logic [NUM_PINS-1:0]  fall_en,
  input  logic                 clr_valid,
  input  logic [NUM_PINS-1:0]  clr_bits,
  output logic [NUM_PINS-1:0]  pending,
  output logic [NUM_PINS-1:0]  pin_filt,
  output logic [EXT_IRQ_W-1:0] ext_interrupts
);

  ctrl_state_e         state_r;
  ctrl_state_e         state_next_s;
  logic [1:0]          init_cnt_r;
  logic                load_s;
  logic                run_s;
  logic [NUM_PINS-1:0] rise_raw_s;
  logic [NUM_PINS-1:0] fall_raw_s;
  logic [NUM_PINS-1:0] edge_s;
  logic [NUM_PINS-1:0] clr_s;
  logic [NUM_PINS-1:0] pending_r;

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_pin_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_pin_filter (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s),
      .pin_in   (pin_in[i]),
      .filt     (pin_filt[i]),
      .rise_raw (rise_raw_s[i]),
      .fall_raw (fall_raw_s[i])
    );
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Count edges spent in INIT while the synchronisers fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_cnt_r <= 2'd0;
    end else if (state_r == INIT) begin
      init_cnt_r <= init_cnt_r + 2'd1;
    end else begin
      init_cnt_r <= 2'd0;
    end
  end

  // Next-state logic: INIT -> LOAD -> RUN, RUN is held until reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT: begin
        if (init_cnt_r == INIT_LAST) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = INIT;
        end
      end
      LOAD:    state_next_s = RUN;
      RUN:     state_next_s = RUN;
      default: state_next_s = INIT;
    endcase
  end

  // State decode: load strobe for the filters, edge enable in RUN only.
  always_comb begin
    load_s = 1'b0;
    run_s  = 1'b0;
    case (state_r)
      INIT: begin
        load_s = 1'b0;
        run_s  = 1'b0;
      end
      LOAD: begin
        load_s = 1'b1;
        run_s  = 1'b0;
      end
      RUN: begin
        load_s = 1'b0;
        run_s  = 1'b1;
      end
      default: begin
        load_s = 1'b0;
        run_s  = 1'b0;
      end
    endcase
  end

  // Qualified edges and the clear mask for this cycle.
  always_comb begin
    edge_s = {NUM_PINS{1'b0}};
    clr_s  = {NUM_PINS{1'b0}};
    if (run_s) begin
      edge_s = (rise_raw_s & rise_en) | (fall_raw_s & fall_en);
    end else begin
      edge_s = {NUM_PINS{1'b0}};
    end
    if (clr_valid) begin
      clr_s = clr_bits;
    end else begin
      clr_s = {NUM_PINS{1'b0}};
    end
  end

  // Pending register: clear first, then OR in new edges so a set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= {NUM_PINS{1'b0}};
    end else begin
      pending_r <= (pending_r & ~clr_s) | edge_s;
    end
  end

  assign pending        = pending_r;
  assign ext_interrupts = map_ext_irq(pending_r & irq_mask);

endmodule

// File: doc/gpio_irq_ctrl.md
# gpio_irq_ctrl

GPIO interrupt controller feeding the core's `ext_interrupts[23:0]` input, which is currently unconnected. It takes the raw `ro_gpio_pinstate` pins and the register block's `rf_gpio_interrupt_mask`. Per pin, it synchronises, glitch-filters and edge-detects the input, then latches edges into a pending register that firmware clears through a write-1-to-clear strobe. It drives the per-pin and aggregate interrupt lines into the core.

## Interface
- `FILTER_CYCLES`, default 4: consecutive stable cycles required before a pin's filtered level changes. 0 bypasses the filter.
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-low reset.
- `pin_in` input 16: raw pin levels (`ro_gpio_pinstate`), asynchronous to `clk`.
- `irq_mask` input 16: per-pin interrupt enable (`rf_gpio_interrupt_mask`); 1 = enabled.
- `rise_en` input 16: per-pin rising-edge detect enable.
- `fall_en` input 16: per-pin falling-edge detect enable.
- `clr_valid` input 1: single-cycle clear strobe.
- `clr_bits` input 16: write-1-to-clear mask, sampled when `clr_valid`=1.
- `pending` output 16: raw pending register (readable by the register block), unmasked.
- `pin_filt` output 16: filtered pin levels.
- `ext_interrupts` output 24: `[15:0]` = `pending & irq_mask`, `[16]` = OR of `[15:0]`, `[23:17]` = 0.

## Operation
- Per pin: 2-flop synchroniser → glitch filter → edge detector.
- Glitch filter:
  - Counter width is clog2(FILTER_CYCLES+1).
  - The counter increments each cycle the synced level differs from `pin_filt`.
  - The counter resets to 0 whenever the synced level equals `pin_filt`.
  - When the counter reaches FILTER_CYCLES, `pin_filt` takes the synced level and the counter clears.
- Edge detector, one cycle after a `pin_filt` transition:
  - rise = `pin_filt` & ~prev & `rise_en`.
  - fall = ~`pin_filt` & prev & `fall_en`.
- Pending update: `pending` next = (`pending` & ~(`clr_valid` ? `clr_bits` : 0)) | rise | fall.
  - Set beats clear for the same bit in the same cycle.
- Edges latch into `pending` regardless of `irq_mask`. The mask gates only `ext_interrupts`, so unmasking a pending bit raises its interrupt on the next cycle.
- Interrupts are level outputs. They hold until cleared.
- Control FSM, three states:
  - INIT: entered on reset. Edge detection is disabled; waits 2 cycles for the synchronisers to fill.
  - LOAD: for one cycle, loads `pin_filt` and prev directly from the synced levels with no edge generated. This suppresses false edges after reset on pins that are already high.
  - RUN: normal operation; no exit except `reset`.
- `rise_en`/`fall_en` changes take effect on the next edge evaluation. They never create an edge by themselves.

## Timing
- Reset (`reset`=0, asynchronous):
  - Synchronisers, `pin_filt`, prev, counters, `pending` = 0.
  - `ext_interrupts` = 0.
  - FSM = INIT.
- Deassertion: reset releases at edge 0. Edges 1–2 are INIT, edge 3 is LOAD, and the block is in RUN from edge 4. Pin changes before RUN never set `pending`.
- Latency: pin change stable before edge N → `pending` bit set at edge N+3+FILTER_CYCLES → `ext_interrupts` visible in the same cycle (combinational from `pending` and `irq_mask`).
- Clear: `clr_valid` at edge M → bit low after edge M; `ext_interrupts` low in the same cycle.
- A pulse shorter than FILTER_CYCLES+1 synced cycles never changes `pin_filt` (FILTER_CYCLES>0).
- Reset mid-operation: all state is lost immediately and the block restarts at INIT; pending interrupts are dropped.
- `clr_valid` is accepted every cycle. There is no back-pressure.

## Structure
- Package `gpio_irq_pkg` holds:
  - NUM_PINS=16, EXT_IRQ_W=24, AGG_IRQ_BIT=16.
  - The FSM state type {INIT, LOAD, RUN}.
  - A SYNC_STAGES=2 constant.
- Sub-module `gpio_pin_filter`, one instance per pin, contains:
  - the synchroniser, filter counter, `pin_filt` flop and prev flop;
  - a `load` input from the FSM.

  It outputs `filt`, `rise_raw` and `fall_raw`. The top level holds the FSM, the enables, the pending register and the output mapping.

## Test plan
- Reset with `pin_in`=16'hFFFF, all enables=1 → after reset release, `pending`=0 forever; `pin_filt`=16'hFFFF from edge 4.
- FILTER_CYCLES=4, pin 3 rises at edge 10 → `pending`=16'h0008 at edge 17; with `irq_mask[3]`=1, `ext_interrupts`=24'h010008.
- 3-cycle pulse on pin 5 (FILTER_CYCLES=4) → `pin_filt[5]` and `pending` unchanged. A 6-cycle pulse → rise then fall latched; only bit 5 set.
- Pin 0 pending, `irq_mask`=0 → `ext_interrupts`=0. Setting `irq_mask[0]`=1 → `ext_interrupts`=24'h010001 the same cycle.
- `clr_valid` with `clr_bits`=16'h0001 in the same cycle as a new rising edge on pin 0 → `pending[0]` stays 1. A clear one cycle later → 0, and bit 16 drops.
- Assert `reset` while `pending`=16'hA5A5 → `pending` and `ext_interrupts` are 0 asynchronously; the FSM re-runs INIT→LOAD→RUN.
